// File: rtl/keypad_matrix_emulator.sv
// Emulates a 4x4 keypad: key codes queued through a small FIFO are replayed as
// timed presses and answered on the active-low row lines against the scanner's column drive.
module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES = 1000,
    parameter int GAP_CYCLES  = 1000,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    key_code,
    input  logic                          key_valid,
    output logic                          key_ready,
    input  logic                          flush,
    input  logic [3:0]                    col,
    output logic [3:0]                    row,
    output logic                          busy,
    output logic                          press_active,
    output logic [3:0]                    pressed_key,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNTF_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         key_q, key_d;
    logic [3:0]         row_q, row_d;

    logic [3:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNTF_W-1:0]  count_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign fifo_full  = (count_q == CNTF_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    // Full blocks a push even when a pop happens in the same cycle.
    assign key_ready  = !fifo_full && !flush;
    assign push       = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= key_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNTF_W'(1);
                2'b01:   count_q <= count_q - CNTF_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!flush && !fifo_empty) begin
                    pop     = 1'b1;
                    key_d   = fifo_mem_q[rd_ptr_q];
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    state_d = ST_PRESS;
                end
            end
            ST_PRESS: begin
                // An abort still passes through a full release gap.
                if (flush || cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // One row bit per matrix row: low only for the pressed key's row while its column is driven.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            assign row_d[gi] = !(press_active && !col[key_q[1:0]] && (key_q[3:2] == 2'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            row_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            row_q   <= row_d;
        end
    end

    assign press_active = (state_q == ST_PRESS);
    assign busy         = (state_q != ST_IDLE);
    assign pressed_key  = key_q;
    assign row          = row_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator with short hold/gap timing and
// hand-computed expectations for rows, press order, timing and flush.
module tb_keypad_matrix_emulator;

    localparam int HOLD  = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'd0;
    logic       key_valid = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] col = 4'b1111;
    logic       key_ready;
    logic [3:0] row;
    logic       busy;
    logic       press_active;
    logic [3:0] pressed_key;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] sweep [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] codes3 [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
    logic [3:0] codes4 [3] = '{4'd3, 4'd9, 4'd12};

    keypad_matrix_emulator #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .FIFO_DEPTH  (DEPTH),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .flush        (flush),
        .col          (col),
        .row          (row),
        .busy         (busy),
        .press_active (press_active),
        .pressed_key  (pressed_key),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_press;
        int n_gap;
        int n_low;
        int lows;
        int run;
        int idx;
        logic prev;
        logic first;
        logic seen;
        logic [3:0] exp_row;

        // 1. Reset holds row released whatever the column drive
        for (int i = 0; i < 4; i++) begin
            col = sweep[i];
            tick();
            check("rst_row", row, 4'b1111);
            check("rst_ready", key_ready, 1'b1);
            check("rst_count", fifo_count, 3'd0);
        end
        check("rst_busy", busy, 1'b0);
        check("rst_key", pressed_key, 4'd0);
        rst = 1'b0;
        col = 4'b1111;
        tick();

        // 2. Single press of key 6 (row 1, column 2) with a column sweep
        key_code = 4'd6;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        check("t2_count_after_push", fifo_count, 3'd1);
        check("t2_not_yet_pressed", press_active, 1'b0);
        tick();
        check("t2_press_start", press_active, 1'b1);
        check("t2_pressed_key", pressed_key, 4'd6);
        check("t2_count_after_pop", fifo_count, 3'd0);
        n_press = 1;
        for (int i = 0; i < HOLD; i++) begin
            col = sweep[i % 4];
            exp_row = (col == 4'b1011) ? 4'b1101 : 4'b1111;
            tick();
            check("t2_row", row, exp_row);
            if (press_active) n_press++;
        end
        check("t2_hold_len", n_press, HOLD);
        check("t2_busy_in_gap", busy, 1'b1);
        col = 4'b1011;
        n_gap = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t2_gap_row", row, 4'b1111);
            if (!busy) break;
            n_gap++;
        end
        check("t2_gap_len", n_gap, GAP);
        col = 4'b1111;

        // 3. Back-to-back pushes: one popped, four queued, sixth refused
        for (int i = 0; i < 6; i++) begin
            key_code = codes3[i];
            key_valid = 1'b1;
            check("t3_ready", key_ready, (i < 5) ? 1'b1 : 1'b0);
            tick();
        end
        key_valid = 1'b0;
        check("t3_count_full", fifo_count, 3'd4);
        check("t3_first_key", pressed_key, 4'd1);
        prev = press_active;
        first = 1'b1;
        run = 0;
        lows = 0;
        idx = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            if (press_active && !prev) begin
                check("t3_order", pressed_key, (idx < 4) ? codes3[idx + 1] : 4'hX);
                check("t3_release_gap", lows, GAP + 1);
                idx++;
                run = 1;
            end else if (press_active) begin
                run++;
            end else if (prev) begin
                if (!first) check("t3_hold_len", run, HOLD);
                first = 1'b0;
                lows = 1;
            end else begin
                lows++;
            end
            prev = press_active;
            if (idx == 4 && !busy) break;
        end
        check("t3_presses", idx, 4);
        check("t3_count_end", fifo_count, 3'd0);

        // 4. Flush in the third cycle of pressing 3
        for (int i = 0; i < 3; i++) begin
            key_code = codes4[i];
            key_valid = 1'b1;
            tick();
        end
        key_valid = 1'b0;
        tick();
        check("t4_pressing", press_active, 1'b1);
        check("t4_key", pressed_key, 4'd3);
        flush = 1'b1;
        #1;
        check("t4_ready_flush", key_ready, 1'b0);
        tick();
        flush = 1'b0;
        check("t4_released", press_active, 1'b0);
        check("t4_busy", busy, 1'b1);
        check("t4_count", fifo_count, 3'd0);
        n_gap = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy) break;
            n_gap++;
        end
        check("t4_gap_len", n_gap, GAP);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (press_active) seen = 1'b1;
        end
        check("t4_no_more_press", seen, 1'b0);

        // 5. Flush beats a simultaneous push
        flush = 1'b1;
        key_code = 4'd5;
        key_valid = 1'b1;
        #1;
        check("t5_ready", key_ready, 1'b0);
        tick();
        flush = 1'b0;
        key_valid = 1'b0;
        check("t5_count", fifo_count, 3'd0);
        tick();
        check("t5_idle", busy, 1'b0);

        // 6. Key 15 with column 3 held low for the whole press
        col = 4'b0111;
        key_code = 4'd15;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        check("t6_press_start", press_active, 1'b1);
        check("t6_row_latency", row, 4'b1111);
        n_low = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (row == 4'b0111) n_low++;
            if (!busy) break;
        end
        check("t6_row_low_len", n_low, HOLD);
        check("t6_row_end", row, 4'b1111);

        // Reset asserted mid-press releases the row without a clock edge
        key_code = 4'd15;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (row == 4'b0111) break;
        end
        check("t1_row_before_rst", row, 4'b0111);
        #2;
        rst = 1'b1;
        #1;
        check("t1_async_row", row, 4'b1111);
        check("t1_async_press", press_active, 1'b0);
        check("t1_async_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        check("t1_async_count", fifo_count, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keypad_matrix_emulator.md
Name: keypad_matrix_emulator

Overview:
- Synthesizable responder for the 4x4 keypad matrix interface: the keypad scanner drives col, and this block answers on row as if physical keys were pressed.
- Key codes are queued through a valid/ready port from a UART bridge, switch bank or self-test sequencer. Each code is replayed as one press of fixed length, followed by a release gap.
- Used on FPGA boards without a physical keypad, and as the bench-side stimulus for the vending machine keypad path.

Parameters:
- HOLD_CYCLES, 1000, clk cycles a key stays pressed; must be >= 1.
- GAP_CYCLES, 1000, clk cycles all keys stay released after each press; must be >= 1.
- FIFO_DEPTH, 4, key codes buffered; power of two, >= 2.
- CNT_W, 16, hold/gap counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- key_code  input  4  key to press; key k sits at row k/4, column k%4.
- key_valid  input  1  key_code is valid this cycle.
- key_ready  output  1  FIFO can accept; transfer happens when key_valid && key_ready at the clk rising edge.
- flush  input  1  synchronous abort: empty the FIFO and release the current key.
- col  input  4  scanner column drive, active-low; the selected column is 0.
- row  output  4  row return, active-low; 4'b1111 means no key.
- busy  output  1  high in PRESS or GAP.
- press_active  output  1  high in PRESS only.
- pressed_key  output  4  code being pressed; holds its last value outside PRESS.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries in the FIFO.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - row=4'b1111, key_ready=1, busy=0, press_active=0, pressed_key=0, fifo_count=0.
  - FSM in IDLE, FIFO empty, counter=0.
  - Asserting rst mid-press releases row at once, with no clock needed.
- FIFO:
  - key_ready = !full && !flush.
  - A push is blocked when full, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - Codes are pressed in order; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, PRESS, GAP.
  - IDLE to PRESS when the FIFO is non-empty at a clk edge. The head is popped, pressed_key is loaded with it, and counter is loaded with HOLD_CYCLES-1.
  - A code pushed into an empty FIFO at edge N is popped at edge N+1, so press_active rises after edge N+1.
  - PRESS: counter decrements each clk. At 0, move to GAP and load counter with GAP_CYCLES-1. press_active is high for exactly HOLD_CYCLES cycles.
  - GAP: counter decrements. At 0, go to IDLE. IDLE re-evaluates the FIFO on the next edge, so consecutive presses are separated by GAP_CYCLES+1 released cycles.
- flush (synchronous):
  - Clears the FIFO.
  - PRESS goes to GAP with counter=GAP_CYCLES-1, so the release is still debounce-clean.
  - GAP keeps counting.
  - IDLE stays in IDLE.
  - flush wins over a simultaneous push; the push is not accepted because key_ready=0.
- Row drive (registered, 1 clk latency from col):
  - With r=pressed_key[3:2] and c=pressed_key[1:0]: row <= (press_active && col[c]==0) ? ~(4'b0001<<r) : 4'b1111.
  - press_active here is the registered value of the current cycle.
  - If several columns are low at once, the rule above still applies unchanged.
  - In GAP and IDLE, row is 4'b1111 regardless of col.
  - col is not synchronized inside this block: the scanner runs on the same clk.
- Counter arithmetic: unsigned CNT_W bits, loaded and decremented only. It never wraps, because every state exits when it reaches 0.

Test Plan:
1. Reset: hold rst=1 while col cycles 1110/1101/1011/0111 -> row=1111, key_ready=1, fifo_count=0. Assert rst during PRESS -> row=1111 asynchronously, within the same cycle.
2. Single press, HOLD=8, GAP=4: push code 6, then sweep col -> press_active high for exactly 8 cycles. row=4'b1101 on the cycle after col=4'b1011, otherwise 1111. Then 4 cycles of GAP and busy drops.
3. Back-to-back, FIFO_DEPTH=4: push 6 codes on consecutive cycles while the first is pressing -> key_ready low when fifo_count=4. Only 5 codes are accepted (1 popped, 4 queued) and pressed in order, each separated by GAP+1 released cycles.
4. Flush mid-press: push codes 3,9,12 and assert flush in cycle 3 of pressing 3 -> press_active drops next cycle, fifo_count=0. Full GAP observed; codes 9 and 12 are never pressed.
5. Flush with simultaneous key_valid -> key_ready=0 in that cycle, the code is not accepted, fifo_count=0.
6. Key 15 while col=4'b0111 is held constant for the whole press -> row=4'b0111 for exactly HOLD_CYCLES cycles, delayed one clk.
